// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: FETCH/EXEC1/EXEC2/HALT control unit for the accumulator CPU
// Ports: clk, rst_n (async, active low); opcode_i, mem_ready_i, acc_zero_i, acc_neg_i, run_i in;
// state_o, datapath strobes (ir_load_o .. shift_in_o), sticky illegal_o, retired_o count out.
module ctrl_sequencer #(
  parameter int OPC_W = 4,
  parameter int CNT_W = 16,
  parameter bit HALT_RESUME = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             mem_ready_i,
  input  logic             acc_zero_i,
  input  logic             acc_neg_i,
  input  logic             run_i,
  output logic [1:0]       state_o,
  output logic             ir_load_o,
  output logic             pc_cnt_en_o,
  output logic             pc_sload_o,
  output logic             addr_sel_o,
  output logic             wren_o,
  output logic             acc_en_o,
  output logic             acc_load_o,
  output logic             acc_src_all_o,
  output logic             addsub_o,
  output logic             shift_in_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);
  typedef enum logic [1:0] {FETCH, EXEC1, EXEC2, HALT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic illegal_q, illegal_d, retire;
  logic ir, pcc, pcs, asel, wr, aen, ald, asrc, as, shin;
  logic [3:0] op;
  logic hi_zero, lda, sta, add, sub, jmp, jmi, jeq, stp, ldi, lsr, asr, mem_op, legal;
  assign op      = opcode_i[3:0];
  assign hi_zero = (opcode_i >> 4) == '0;
  assign lda     = hi_zero && op == 4'b0000;
  assign sta     = hi_zero && op == 4'b0001;
  assign add     = hi_zero && op == 4'b0010;
  assign sub     = hi_zero && op == 4'b0011;
  assign jmp     = hi_zero && op == 4'b0100;
  assign jmi     = hi_zero && op == 4'b0101;
  assign jeq     = hi_zero && op == 4'b0110;
  assign stp     = hi_zero && op == 4'b0111;
  assign ldi     = hi_zero && op == 4'b1000;
  assign lsr     = hi_zero && op == 4'b1010;
  assign asr     = hi_zero && op == 4'b1011;
  assign mem_op  = lda | sta | add | sub;
  assign legal   = mem_op | jmp | jmi | jeq | stp | ldi | lsr | asr;
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    ir = 1'b0; pcc = 1'b0; pcs = 1'b0; asel = 1'b0; wr = 1'b0;
    aen = 1'b0; ald = 1'b0; asrc = 1'b0; as = 1'b0; shin = 1'b0;
    unique case (state_q)
      FETCH: begin
        ir      = mem_ready_i;
        pcc     = mem_ready_i;
        state_d = mem_ready_i ? EXEC1 : FETCH;
      end
      EXEC1: begin
        if (mem_op) begin
          asel    = 1'b1;
          wr      = sta & mem_ready_i;
          retire  = sta & mem_ready_i;
          state_d = !mem_ready_i ? EXEC1 : sta ? FETCH : EXEC2;
        end else begin
          aen       = ldi | lsr | asr;
          ald       = ldi;
          asrc      = lsr | asr;
          shin      = asr & acc_neg_i;
          pcs       = jmp | (jeq & acc_zero_i) | (jmi & acc_neg_i);
          illegal_d = illegal_q | ~legal;
          retire    = 1'b1;
          state_d   = stp ? HALT : FETCH;
        end
      end
      EXEC2: begin
        aen     = 1'b1;
        ald     = 1'b1;
        asrc    = 1'b1;
        as      = ~sub;
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT: state_d = (HALT_RESUME && run_i) ? FETCH : HALT;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  // Strobes are gated by rst_n so an instruction aborted by reset emits nothing.
  assign {ir_load_o, pc_cnt_en_o, pc_sload_o, addr_sel_o, wren_o, acc_en_o, acc_load_o,
          acc_src_all_o, addsub_o, shift_in_o} =
         rst_n ? {ir, pcc, pcs, asel, wr, aen, ald, asrc, as, shin} : 10'b0;
  assign state_o   = state_q;
  assign illegal_o = illegal_q;
  assign retired_o = retired_q;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: scoreboard bench for ctrl_sequencer (default and CNT_W=4/HALT_RESUME=0 builds)
module tb_ctrl_sequencer;
  localparam logic [3:0] LDA = 4'b0000, STA = 4'b0001, ADD = 4'b0010, SUB = 4'b0011,
                         JMP = 4'b0100, JMI = 4'b0101, JEQ = 4'b0110, STP = 4'b0111,
                         LDI = 4'b1000, LSR = 4'b1010, ASR = 4'b1011, BAD = 4'b1111;
  localparam logic [1:0] F = 2'd0, E1 = 2'd1, E2 = 2'd2, H = 2'd3;
  localparam logic [9:0] K_NONE = 10'b0000000000, K_FET = 10'b1100000000,
                         K_MEM  = 10'b0001000000, K_WR  = 10'b0001100000,
                         K_ADD  = 10'b0000011110, K_SUB = 10'b0000011100,
                         K_LDI  = 10'b0000011000, K_SH  = 10'b0000010100,
                         K_ASR  = 10'b0000010101, K_JMP = 10'b0010000000;
  typedef struct {
    bit          sel;
    logic [1:0]  st;
    logic [9:0]  s;
    logic        ill;
    logic [15:0] ret;
  } exp_t;
  exp_t q[$];
  logic clk = 0, rna = 0, rnb = 0, mr = 0, z = 0, n = 0, run = 0;
  logic [3:0] opc = 4'b0;
  logic [1:0] sta_a, sta_b;
  logic [9:0] sa, sb;
  logic ila, ilb;
  logic [15:0] ra;
  logic [3:0] rb;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  ctrl_sequencer dut_a (
    .clk(clk), .rst_n(rna), .opcode_i(opc), .mem_ready_i(mr), .acc_zero_i(z),
    .acc_neg_i(n), .run_i(run), .state_o(sta_a), .ir_load_o(sa[9]), .pc_cnt_en_o(sa[8]),
    .pc_sload_o(sa[7]), .addr_sel_o(sa[6]), .wren_o(sa[5]), .acc_en_o(sa[4]),
    .acc_load_o(sa[3]), .acc_src_all_o(sa[2]), .addsub_o(sa[1]), .shift_in_o(sa[0]),
    .illegal_o(ila), .retired_o(ra)
  );
  ctrl_sequencer #(.CNT_W(4), .HALT_RESUME(1'b0)) dut_b (
    .clk(clk), .rst_n(rnb), .opcode_i(opc), .mem_ready_i(mr), .acc_zero_i(z),
    .acc_neg_i(n), .run_i(run), .state_o(sta_b), .ir_load_o(sb[9]), .pc_cnt_en_o(sb[8]),
    .pc_sload_o(sb[7]), .addr_sel_o(sb[6]), .wren_o(sb[5]), .acc_en_o(sb[4]),
    .acc_load_o(sb[3]), .acc_src_all_o(sb[2]), .addsub_o(sb[1]), .shift_in_o(sb[0]),
    .illegal_o(ilb), .retired_o(rb)
  );
  task automatic cyc(input bit sel, input bit rn, input logic [3:0] o, input bit m, zz, nn, r,
                     input logic [1:0] es, input logic [9:0] ess, input bit ei, input int er);
    exp_t e;
    rna = sel ? 1'b0 : rn;
    rnb = sel ? rn : 1'b0;
    opc = o; mr = m; z = zz; n = nn; run = r;
    e.sel = sel; e.st = es; e.s = ess; e.ill = ei; e.ret = 16'(er);
    q.push_back(e);
    @(posedge clk); #1;
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      logic [1:0] ast;
      logic [9:0] as;
      logic ai;
      logic [15:0] ar;
      e   = q.pop_front();
      ast = e.sel ? sta_b : sta_a;
      as  = e.sel ? sb : sa;
      ai  = e.sel ? ilb : ila;
      ar  = e.sel ? {12'b0, rb} : ra;
      nvec++;
      if (ast !== e.st || as !== e.s || ai !== e.ill || ar !== e.ret) begin
        nerr++;
        $display("FAIL vec%0d dut%0d: state=%0d strobes=%b illegal=%b retired=%0d, expected state=%0d strobes=%b illegal=%b retired=%0d",
                 nvec, e.sel, ast, as, ai, ar, e.st, e.s, e.ill, e.ret);
      end
    end
  initial begin
    @(posedge clk); #1;
    cyc(0, 0, LDA, 1, 0, 0, 0, F,  K_NONE, 0, 0);
    cyc(0, 1, LDA, 1, 0, 0, 0, F,  K_FET,  0, 0);
    cyc(0, 1, LDA, 1, 0, 0, 0, E1, K_MEM,  0, 0);
    cyc(0, 1, LDA, 1, 0, 0, 0, E2, K_ADD,  0, 0);
    cyc(0, 1, STA, 1, 0, 0, 0, F,  K_FET,  0, 1);
    cyc(0, 1, STA, 0, 0, 0, 0, E1, K_MEM,  0, 1);
    cyc(0, 1, STA, 0, 0, 0, 0, E1, K_MEM,  0, 1);
    cyc(0, 1, STA, 1, 0, 0, 0, E1, K_WR,   0, 1);
    cyc(0, 1, JEQ, 0, 0, 0, 1, F,  K_NONE, 0, 2);
    cyc(0, 1, JEQ, 1, 0, 0, 0, F,  K_FET,  0, 2);
    cyc(0, 1, JEQ, 1, 1, 0, 0, E1, K_JMP,  0, 2);
    cyc(0, 1, JEQ, 1, 0, 0, 0, F,  K_FET,  0, 3);
    cyc(0, 1, JEQ, 1, 0, 1, 0, E1, K_NONE, 0, 3);
    cyc(0, 1, JMI, 1, 0, 0, 0, F,  K_FET,  0, 4);
    cyc(0, 1, JMI, 1, 0, 1, 0, E1, K_JMP,  0, 4);
    cyc(0, 1, ADD, 1, 0, 0, 0, F,  K_FET,  0, 5);
    cyc(0, 1, ADD, 1, 0, 0, 0, E1, K_MEM,  0, 5);
    cyc(0, 1, ADD, 1, 0, 0, 0, E2, K_ADD,  0, 5);
    cyc(0, 1, SUB, 1, 0, 0, 0, F,  K_FET,  0, 6);
    cyc(0, 1, SUB, 1, 0, 0, 0, E1, K_MEM,  0, 6);
    cyc(0, 1, SUB, 1, 0, 0, 0, E2, K_SUB,  0, 6);
    cyc(0, 1, ASR, 1, 0, 0, 0, F,  K_FET,  0, 7);
    cyc(0, 1, ASR, 1, 0, 1, 0, E1, K_ASR,  0, 7);
    cyc(0, 1, LSR, 1, 0, 0, 0, F,  K_FET,  0, 8);
    cyc(0, 1, LSR, 1, 0, 1, 0, E1, K_SH,   0, 8);
    cyc(0, 1, LDI, 1, 0, 0, 0, F,  K_FET,  0, 9);
    cyc(0, 1, LDI, 1, 0, 0, 0, E1, K_LDI,  0, 9);
    cyc(0, 1, JMP, 1, 0, 0, 0, F,  K_FET,  0, 10);
    cyc(0, 1, JMP, 1, 0, 0, 0, E1, K_JMP,  0, 10);
    cyc(0, 1, BAD, 1, 0, 0, 0, F,  K_FET,  0, 11);
    cyc(0, 1, BAD, 1, 0, 0, 0, E1, K_NONE, 0, 11);
    cyc(0, 1, STP, 1, 0, 0, 0, F,  K_FET,  1, 12);
    cyc(0, 1, STP, 1, 0, 0, 0, E1, K_NONE, 1, 12);
    cyc(0, 1, LDA, 1, 0, 0, 0, H,  K_NONE, 1, 13);
    cyc(0, 1, LDA, 1, 0, 0, 1, H,  K_NONE, 1, 13);
    cyc(0, 1, LDA, 1, 0, 0, 0, F,  K_FET,  1, 13);
    cyc(0, 1, LDA, 1, 0, 0, 0, E1, K_MEM,  1, 13);
    cyc(0, 1, LDA, 1, 0, 0, 0, E2, K_ADD,  1, 13);
    cyc(0, 0, LDA, 1, 0, 0, 0, F,  K_NONE, 0, 0);
    cyc(1, 0, JMP, 1, 0, 0, 0, F,  K_NONE, 0, 0);
    for (int i = 0; i < 17; i++) begin
      cyc(1, 1, JMP, 1, 0, 0, 0, F,  K_FET, 0, i % 16);
      cyc(1, 1, JMP, 1, 0, 0, 0, E1, K_JMP, 0, i % 16);
    end
    cyc(1, 1, STP, 1, 0, 0, 0, F,  K_FET,  0, 1);
    cyc(1, 1, STP, 1, 0, 0, 0, E1, K_NONE, 0, 1);
    cyc(1, 1, STP, 1, 0, 0, 1, H,  K_NONE, 0, 2);
    cyc(1, 1, STP, 1, 0, 0, 0, H,  K_NONE, 0, 2);
    cyc(1, 1, STP, 1, 0, 0, 1, H,  K_NONE, 0, 2);
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expected vectors left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
